vga_sync_rx: RTL and testbench
==============================

VGA_SYNC_RX -- requirements
Module: vga_sync_rx

Interface
- REQ-001: Parameter H_TOTAL, default 800, pixel periods per line.
- REQ-002: Parameter H_START, default 144, hcnt value of first active pixel (sync 96 + back porch 48).
- REQ-003: Parameter H_ACTIVE, default 640, active pixels per line.
- REQ-004: Parameter V_TOTAL, default 525, lines per frame.
- REQ-005: Parameter V_START, default 35, vcnt value of first active line (sync 2 + back porch 33).
- REQ-006: Parameter V_ACTIVE, default 480, active lines per frame.
- REQ-007: clk  input  1  single clock; all logic on its rising edge.
- REQ-008: reset  input  1  asynchronous, active-high.
- REQ-009: pix_en  input  1  pixel strobe; when low, all state and outputs hold.
- REQ-010: hsync, vsync  input  1 each  active-low syncs, synchronous to clk.
- REQ-011: r_in, g_in, b_in  input  8 each  incoming pixel colour.
- REQ-012: x, y  output  10 each  active-area coordinates of the current output pixel.
- REQ-013: r, g, b  output  8 each  captured colour, registered.
- REQ-014: pixel_valid  output  1  high when x/y/r/g/b denote a locked active pixel.
- REQ-015: frame_start  output  1  one-cycle pulse at each vsync falling edge.
- REQ-016: locked  output  1  high in LOCKED state.
- REQ-017: sync_err  output  1  one-cycle pulse on loss of lock.

Function
- REQ-018: The block shall register hsync/vsync on each pix_en cycle; an edge shall be a high-to-low change between consecutive pix_en samples.
- REQ-019: hcnt (10-bit) shall load 0 on the pix_en cycle an hsync falling edge is detected, otherwise increment, saturating at 1023.
- REQ-020: vcnt (10-bit) shall increment on each hsync falling edge and load 0 on an hsync falling edge coinciding with, or first following, a vsync falling edge.
- REQ-021: Active pixel shall be H_START <= hcnt < H_START+H_ACTIVE and V_START <= vcnt < V_START+V_ACTIVE; x = hcnt-H_START, y = vcnt-V_START.
- REQ-022: Outputs x, y, r, g, b, pixel_valid shall update one clk after the pix_en sample they describe (latency 1 pixel).
- REQ-023: pixel_valid shall be high only when active and locked; otherwise low with x, y, r, g, b forced to 0.
- REQ-024: States SEARCH, MEASURE, LOCKED; reset state SEARCH.
- REQ-025: SEARCH -> MEASURE on vsync falling edge.
- REQ-026: MEASURE: a line is bad if hcnt+1 != H_TOTAL at an hsync falling edge; at next vsync falling edge -> LOCKED if no bad line and line count == V_TOTAL, else stay MEASURE with counts cleared.
- REQ-027: LOCKED -> SEARCH with a sync_err pulse on any bad line, hcnt saturation, or vsync falling edge with line count != V_TOTAL.
- REQ-028: Lock loss shall deassert locked and pixel_valid in the same cycle sync_err pulses.
- REQ-029: frame_start shall pulse in every state, independent of lock.

Reset
- REQ-030: Reset shall asynchronously clear all outputs to 0, counters to 0, sync samples to 1 (idle) and state to SEARCH.
- REQ-031: Reset mid-frame shall require a full SEARCH/MEASURE sequence before pixel_valid reasserts.

Configuration
- REQ-032: With VGA_RX_FRAMESUM_EN defined, the block shall add output frame_sum (16 bits), equal to the modulo-2^16 sum of r+g+b over all valid pixels of the last complete locked frame, latched at vsync falling edge, reset 0.
- REQ-033: Without VGA_RX_FRAMESUM_EN, the frame_sum port and accumulator shall not exist; all other behaviour shall be identical.

Verification
- REQ-034: Stimulus: standard 640x480 timing, pix_en every cycle, 3 frames -> locked rises at 2nd vsync falling edge; 640x480 pixel_valid pulses in frame 3.
- REQ-035: Stimulus: r_in = hcnt[7:0] on locked frame -> x=0 carries r=144&255=144, x=639 carries r=(783)&255=15, y=0..479.
- REQ-036: Stimulus: while locked, one line of 799 periods -> sync_err pulses once, locked=0, state SEARCH; relock after 2 good frames.
- REQ-037: Stimulus: hsync held high 1100 pix_en cycles while locked -> sync_err at hcnt saturation, pixel_valid 0.
- REQ-038: Stimulus: pix_en toggling 1/0 -> outputs hold on pix_en=0 cycles; same results as continuous case.
- REQ-039: Stimulus: reset asserted mid-line in LOCKED -> all outputs 0 immediately, frame_start unaffected after release; with VGA_RX_FRAMESUM_EN, constant r=g=b=1 frame -> frame_sum = 921600 mod 65536 = 4096.

Source files
------------

// File: rtl/vga_sync_rx.sv
// vga_sync_rx: recovers active-area coordinates, colour and lock status from VGA syncs.
// Define VGA_RX_FRAMESUM_EN to add the frame_sum checksum of the last locked frame.
module vga_sync_rx #(
    parameter int H_TOTAL  = 800,
    parameter int H_START  = 144,
    parameter int H_ACTIVE = 640,
    parameter int V_TOTAL  = 525,
    parameter int V_START  = 35,
    parameter int V_ACTIVE = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [7:0]  r_in,
    input  logic [7:0]  g_in,
    input  logic [7:0]  b_in,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        pixel_valid,
    output logic        frame_start,
    output logic        locked,
`ifdef VGA_RX_FRAMESUM_EN
    output logic [15:0] frame_sum,
`endif
    output logic        sync_err
);
    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
    localparam logic [10:0] HB = 11'(H_START);
    localparam logic [10:0] HE = 11'(H_START + H_ACTIVE);
    localparam logic [10:0] VB = 11'(V_START);
    localparam logic [10:0] VE = 11'(V_START + V_ACTIVE);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LINES = 10'(V_TOTAL);
    state_t state, state_nxt;
    logic hs_q, vs_q, vs_pend, bad_q;
    logic hs_fall, vs_fall, bad_line, sat, lines_ok, active, valid_nxt, lose;
    logic [9:0] hcnt, vcnt, lcnt, hcnt_nxt, vcnt_nxt;
    // Everything below describes the sample being taken now, so outputs lag it by one clock.
    always_comb begin
        hs_fall = pix_en & hs_q & ~hsync;
        vs_fall = pix_en & vs_q & ~vsync;
        hcnt_nxt = hs_fall ? 10'd0 : (hcnt == 10'd1023 ? hcnt : hcnt + 10'd1);
        vcnt_nxt = hs_fall ? ((vs_fall | vs_pend) ? 10'd0 : vcnt + 10'd1) : vcnt;
        bad_line = hs_fall && hcnt != H_LAST;
        sat = pix_en && hcnt_nxt == 10'd1023;
        lines_ok = lcnt == V_LINES;
        active = {1'b0, hcnt_nxt} >= HB && {1'b0, hcnt_nxt} < HE &&
                 {1'b0, vcnt_nxt} >= VB && {1'b0, vcnt_nxt} < VE;
        state_nxt = state;
        lose = 1'b0;
        case (state)
            SEARCH:  state_nxt = vs_fall ? MEASURE : SEARCH;
            MEASURE: state_nxt = (vs_fall && !bad_q && !bad_line && lines_ok) ? LOCKED : MEASURE;
            LOCKED: begin
                lose = bad_line | sat | (vs_fall & ~lines_ok);
                state_nxt = lose ? SEARCH : LOCKED;
            end
            default: state_nxt = SEARCH;
        endcase
        valid_nxt = active && state_nxt == LOCKED;
    end
    assign locked = state == LOCKED;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= SEARCH;
            hs_q        <= 1'b1;
            vs_q        <= 1'b1;
            vs_pend     <= 1'b0;
            bad_q       <= 1'b0;
            hcnt        <= '0;
            vcnt        <= '0;
            lcnt        <= '0;
            x           <= '0;
            y           <= '0;
            r           <= '0;
            g           <= '0;
            b           <= '0;
            pixel_valid <= 1'b0;
            frame_start <= 1'b0;
            sync_err    <= 1'b0;
        end else if (pix_en) begin
            state       <= state_nxt;
            hs_q        <= hsync;
            vs_q        <= vsync;
            vs_pend     <= hs_fall ? 1'b0 : (vs_pend | vs_fall);
            // bad lines and line count restart with each frame; a coincident hsync edge opens the new frame
            bad_q       <= vs_fall ? 1'b0 : (bad_q | bad_line);
            hcnt        <= hcnt_nxt;
            vcnt        <= vcnt_nxt;
            lcnt        <= vs_fall ? {9'd0, hs_fall} : lcnt + {9'd0, hs_fall && lcnt != 10'd1023};
            x           <= valid_nxt ? hcnt_nxt - 10'(H_START) : '0;
            y           <= valid_nxt ? vcnt_nxt - 10'(V_START) : '0;
            r           <= valid_nxt ? r_in : '0;
            g           <= valid_nxt ? g_in : '0;
            b           <= valid_nxt ? b_in : '0;
            pixel_valid <= valid_nxt;
            frame_start <= vs_fall;
            sync_err    <= lose;
        end
    end
`ifdef VGA_RX_FRAMESUM_EN
    logic [15:0] acc;
    logic frame_ok;
    // frame_ok stays set only if the whole frame since the last vsync edge was locked
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            frame_ok  <= 1'b0;
            frame_sum <= '0;
        end else if (pix_en) begin
            acc       <= vs_fall ? 16'd0 :
                         acc + (valid_nxt ? 16'(r_in) + 16'(g_in) + 16'(b_in) : 16'd0);
            frame_ok  <= vs_fall ? state_nxt == LOCKED : frame_ok & (state_nxt == LOCKED);
            frame_sum <= (vs_fall && frame_ok && state_nxt == LOCKED) ? acc : frame_sum;
        end
    end
`endif
endmodule

// File: tb/tb_vga_sync_rx.sv
// tb_vga_sync_rx: scoreboard bench for vga_sync_rx on a reduced 40x20 raster.
module tb_vga_sync_rx;
    localparam int HT = 40, HS = 12, HA = 20, VT = 20, VS = 4, VA = 12, HSW = 4, VSW = 2;
    typedef struct packed {logic [9:0] x, y; logic [7:0] r, g, b;} pix_t;
    logic clk = 1'b0, reset = 1'b0, pix_en = 1'b0, hsync = 1'b1, vsync = 1'b1;
    logic [7:0] r_in = '0, g_in = '0, b_in = '0;
    logic [9:0] x, y;
    logic [7:0] r, g, b;
    logic pixel_valid, frame_start, locked, sync_err;
`ifdef VGA_RX_FRAMESUM_EN
    logic [15:0] frame_sum;
`endif
    vga_sync_rx #(.H_TOTAL(HT), .H_START(HS), .H_ACTIVE(HA),
                  .V_TOTAL(VT), .V_START(VS), .V_ACTIVE(VA)) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
        .r_in(r_in), .g_in(g_in), .b_in(b_in), .x(x), .y(y), .r(r), .g(g), .b(b),
        .pixel_valid(pixel_valid), .frame_start(frame_start), .locked(locked),
`ifdef VGA_RX_FRAMESUM_EN
        .frame_sum(frame_sum),
`endif
        .sync_err(sync_err));
    always #5 clk = ~clk;
    pix_t sb[$];
    int total = 0, bad = 0;
    int nvalid = 0, fs_cnt = 0, err_cnt = 0, rise_cnt = 0, rise_fs = 0, step_idx = 0, err_idx = -1;
    bit tog = 0, cst = 0;
    logic prev_locked = 1'b0;
    logic [7:0] first_r = '0, last_r = '0;
    logic [9:0] last_x = '0, last_y = '0;

    function automatic logic [47:0] snap();
        return {x, y, r, g, b, pixel_valid, frame_start, locked, sync_err};
    endfunction

    task automatic apply(input logic hs, input logic vs, input int h, input int v, input bit exp);
        pix_t e, got;
        logic [47:0] s;
        hsync = hs;
        vsync = vs;
        r_in = cst ? 8'd1 : 8'(h);
        g_in = cst ? 8'd1 : 8'(v);
        b_in = cst ? 8'd1 : 8'(h * 3 + v);
        if (exp && h >= HS && h < HS + HA && v >= VS && v < VS + VA)
            sb.push_back('{10'(h - HS), 10'(v - VS), r_in, g_in, b_in});
        pix_en = 1'b1;
        @(posedge clk);
        #1;
        step_idx++;
        got = '{x, y, r, g, b};
        total++;
        if (pixel_valid) begin
            nvalid++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL pixel_unexpected: got x=%0d y=%0d r=%0d, required no valid pixel", x, y, r);
            end else begin
                e = sb.pop_front();
                if (got !== e) begin
                    bad++;
                    $display("FAIL pixel: got %h, required %h", got, e);
                end
            end
            if (x == 0 && y == 0) first_r = r;
            last_x = x;
            last_y = y;
            last_r = r;
        end else if (got !== '0) begin
            bad++;
            $display("FAIL idle_zero: got %h, required 0 while pixel_valid=0", got);
        end
        if (frame_start) fs_cnt++;
        if (sync_err) begin
            err_cnt++;
            if (err_idx < 0) err_idx = step_idx;
            total++;
            if (locked !== 1'b0 || pixel_valid !== 1'b0) begin
                bad++;
                $display("FAIL err_drop: got locked=%b valid=%b, required 0 0", locked, pixel_valid);
            end
        end
        if (locked && !prev_locked) begin
            rise_cnt++;
            rise_fs = fs_cnt;
        end
        prev_locked = locked;
        if (tog) begin
            s = snap();
            pix_en = 1'b0;
            @(posedge clk);
            #1;
            total++;
            if (snap() !== s) begin
                bad++;
                $display("FAIL hold: got %h, required %h", snap(), s);
            end
        end
    endtask

    task automatic gen_line(input int v, input int len, input bit exp);
        for (int h = 0; h < len; h++) apply(!(h < HSW), !(v < VSW), h, v, exp);
    endtask

    task automatic gen_frame(input bit exp, input int v0 = 0);
        for (int v = v0; v < VT; v++) gen_line(v, HT, exp);
    endtask

    task automatic do_reset();
        pix_en = 1'b0;
        hsync = 1'b1;
        vsync = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        prev_locked = 1'b0;
        nvalid = 0; fs_cnt = 0; err_cnt = 0; rise_cnt = 0; rise_fs = 0;
    endtask

    task automatic chk(input string name, input int got, input int req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic test_reset();
        pix_en = 1'b1;
        #7;
        reset = 1'b1;
        #1;
        total++;
        if (snap() !== '0) begin
            bad++;
            $display("FAIL reset_async: got %h, required 0", snap());
        end
        @(posedge clk);
        #1;
        total++;
        if (snap() !== '0) begin
            bad++;
            $display("FAIL reset_hold: got %h, required 0", snap());
        end
        reset = 1'b0;
    endtask

    task automatic test_lock();
        do_reset();
        gen_frame(0, VSW);
        gen_frame(0);
        gen_frame(1);
        chk("lock_rises", rise_cnt, 1);
        chk("lock_at_vs2", rise_fs, 2);
        chk("frame_starts", fs_cnt, 2);
        chk("lock_valid_cnt", nvalid, HA * VA);
        chk("lock_sb_left", sb.size(), 0);
        chk("lock_locked", int'(locked), 1);
        chk("lock_errs", err_cnt, 0);
    endtask

    task automatic test_colour();
        nvalid = 0;
        gen_frame(1);
        chk("col_first_r", int'(first_r), HS);
        chk("col_last_r", int'(last_r), HS + HA - 1);
        chk("col_last_x", int'(last_x), HA - 1);
        chk("col_last_y", int'(last_y), VA - 1);
        chk("col_valid_cnt", nvalid, HA * VA);
    endtask

    task automatic test_short_line();
        err_cnt = 0; rise_cnt = 0; err_idx = -1;
        gen_line(0, HT, 1);
        gen_line(1, HT - 1, 1);
        for (int v = 2; v < VT; v++) gen_line(v, HT, 0);
        chk("short_err", err_cnt, 1);
        chk("short_unlocked", int'(locked), 0);
        gen_frame(0);
        chk("short_no_early", rise_cnt, 0);
        nvalid = 0;
        gen_frame(1);
        chk("short_relock", rise_cnt, 1);
        chk("short_valid_cnt", nvalid, HA * VA);
        chk("short_sb_left", sb.size(), 0);
    endtask

    task automatic test_saturation();
        err_cnt = 0; err_idx = -1; rise_cnt = 0;
        gen_line(0, HT, 1);
        step_idx = 0;
        for (int i = 0; i < 1100; i++) apply(1'b1, 1'b1, HT + i, 1, 0);
        chk("sat_err", err_cnt, 1);
        chk("sat_err_at", err_idx, 1023 - HT + 1);
        chk("sat_valid", int'(pixel_valid), 0);
        for (int v = 2; v < VT; v++) gen_line(v, HT, 0);
        gen_frame(0);
        nvalid = 0;
        gen_frame(1);
        chk("sat_relock", rise_cnt, 1);
        chk("sat_valid_cnt", nvalid, HA * VA);
    endtask

    task automatic test_toggle();
        do_reset();
        tog = 1;
        gen_frame(0, VSW);
        gen_frame(0);
        nvalid = 0;
        gen_frame(1);
        tog = 0;
        chk("tog_lock_at_vs2", rise_fs, 2);
        chk("tog_valid_cnt", nvalid, HA * VA);
        chk("tog_sb_left", sb.size(), 0);
    endtask

    task automatic test_reset_mid();
        for (int v = 0; v < 6; v++) gen_line(v, HT, 1);
        for (int h = 0; h <= 20; h++) apply(!(h < HSW), 1'b1, h, 6, 1);
        chk("mid_pre_valid", int'(pixel_valid), 1);
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (snap() !== '0) begin
            bad++;
            $display("FAIL mid_reset_zero: got %h, required 0", snap());
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        prev_locked = 1'b0;
        fs_cnt = 0; rise_cnt = 0; nvalid = 0;
        for (int h = 21; h < HT; h++) apply(1'b1, 1'b1, h, 6, 0);
        for (int v = 7; v < VT; v++) gen_line(v, HT, 0);
        gen_frame(0);
        chk("mid_no_valid", nvalid, 0);
        gen_frame(1);
        chk("mid_frame_starts", fs_cnt, 2);
        chk("mid_relock", rise_cnt, 1);
        chk("mid_valid_cnt", nvalid, HA * VA);
    endtask

`ifdef VGA_RX_FRAMESUM_EN
    task automatic test_framesum();
        cst = 1;
        gen_frame(1);
        gen_line(0, HT, 0);
        cst = 0;
        chk("frame_sum", int'(frame_sum), (HA * VA * 3) % 65536);
    endtask
`endif

    initial begin
        test_reset();
        test_lock();
        test_colour();
        test_short_line();
        test_saturation();
        test_toggle();
        test_reset_mid();
`ifdef VGA_RX_FRAMESUM_EN
        test_framesum();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
